// File: rtl/unidade_load_store.sv
// Load/store initiator for a 64-bit x 2**ABITS word data memory.
// Sub-doubleword stores are done as read-modify-write; loads are extracted and extended.
module unidade_load_store #(
  parameter int BITS  = 64,
  parameter int ABITS = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_op_store,
  input  logic [2:0]       i_funct3,
  input  logic [ABITS+2:0] i_addr,
  input  logic [BITS-1:0]  i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [BITS-1:0]  o_rdata,
  output logic             o_misaligned,
  output logic             o_illegal,
  output logic [ABITS-1:0] o_mem_addr,
  output logic             o_mem_we,
  output logic [BITS-1:0]  o_mem_din,
  input  logic [BITS-1:0]  i_mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           r_state, w_next;
  logic             r_op_store;
  logic [2:0]       r_funct3;
  logic [2:0]       r_off;
  logic [BITS-1:0]  r_wdata;
  logic [ABITS-1:0] r_mem_addr;
  logic [BITS-1:0]  r_mem_din;
  logic [BITS-1:0]  r_rdata;
  logic             r_mis;
  logic             r_ill;

  logic             w_in_ill, w_in_mis, w_accept;
  logic [5:0]       w_shamt;
  logic [BITS-1:0]  w_shifted, w_ext, w_size_mask, w_mask, w_merged;

  // Decode of the incoming request; a malformed funct3 is reported as illegal only.
  always_comb begin
    w_in_ill = i_op_store ? i_funct3[2] : (i_funct3 == 3'b111);
    case (i_funct3[1:0])
      2'b00:   w_in_mis = 1'b0;
      2'b01:   w_in_mis = i_addr[0];
      2'b10:   w_in_mis = |i_addr[1:0];
      default: w_in_mis = |i_addr[2:0];
    endcase
    w_in_mis = w_in_mis & ~w_in_ill;
  end

  assign w_accept = (r_state == S_IDLE) && i_start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (i_start) begin
          if (w_in_ill || w_in_mis)                       w_next = S_DONE;
          else if (i_op_store && i_funct3[1:0] == 2'b11)  w_next = S_WRITE;
          else                                            w_next = S_READ;
        end
      S_READ:  w_next = r_op_store ? S_WRITE : S_DONE;
      S_WRITE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: align the addressed field to bit 0 for loads, and to the offset for store merge.
  assign w_shamt   = {r_off, 3'b000};
  assign w_shifted = i_mem_dout >> w_shamt;

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{(BITS-8){w_shifted[7]}},   w_shifted[7:0]};
      3'b001:  w_ext = {{(BITS-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_ext = {{(BITS-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_ext = {{(BITS-8){1'b0}},           w_shifted[7:0]};
      3'b101:  w_ext = {{(BITS-16){1'b0}},          w_shifted[15:0]};
      3'b110:  w_ext = {{(BITS-32){1'b0}},          w_shifted[31:0]};
      default: w_ext = w_shifted;
    endcase
    case (r_funct3[1:0])
      2'b00:   w_size_mask = {{(BITS-8){1'b0}},  8'hFF};
      2'b01:   w_size_mask = {{(BITS-16){1'b0}}, 16'hFFFF};
      2'b10:   w_size_mask = {{(BITS-32){1'b0}}, 32'hFFFF_FFFF};
      default: w_size_mask = '1;
    endcase
    w_mask   = w_size_mask << w_shamt;
    w_merged = (i_mem_dout & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_op_store <= 1'b0;
      r_funct3   <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_rdata    <= '0;
      r_mis      <= 1'b0;
      r_ill      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_store <= i_op_store;
        r_funct3   <= i_funct3;
        r_off      <= i_addr[2:0];
        r_wdata    <= i_wdata;
        r_mem_addr <= i_addr[ABITS+2:3];
        r_mis      <= w_in_mis;
        r_ill      <= w_in_ill;
        if (w_next == S_WRITE) r_mem_din <= i_wdata;
      end
      if (r_state == S_READ) begin
        if (r_op_store) r_mem_din <= w_merged;
        else            r_rdata   <= w_ext;
      end
    end
  end

  // mem_we decodes straight from state so an async reset drops it at once.
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_mem_we     = (r_state == S_WRITE);
  assign o_misaligned = o_done & r_mis;
  assign o_illegal    = o_done & r_ill;
  assign o_rdata      = r_rdata;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_din    = r_mem_din;

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a behavioural 32x64 data memory.
module tb_unidade_load_store;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, op_store;
  logic [2:0]  funct3;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic        busy, done, misaligned, illegal, mem_we;
  logic [63:0] rdata, mem_din, mem_dout;
  logic [4:0]  mem_addr;

  logic [63:0] mem [32] = '{default: 64'h0};
  logic        pl_en = 1'b0;
  logic [4:0]  pl_a = '0;
  logic [63:0] pl_d = '0;

  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [4:0]  we_addr;
  logic [63:0] we_din;
  int          edges;
  int          dones;

  always #5 clk = ~clk;

  unidade_load_store #(.BITS(64), .ABITS(5)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op_store(op_store),
    .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_misaligned(misaligned), .o_illegal(illegal),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    if (pl_en)  mem[pl_a]     <= pl_d;
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_din  = mem_din;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [63:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request from IDLE and returns the edge count from the start edge to done.
  task automatic req(input logic st, input logic [2:0] f3, input logic [7:0] a,
                     input logic [63:0] wd, output int n);
    int guard;
    guard = 0;
    while (busy && guard < 20) begin @(posedge clk); #1; guard++; end
    we_cnt = 0;
    start = 1'b1; op_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 10) begin @(posedge clk); #1; n++; end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mdin", mem_din, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    preload(5'd2, 64'h5E);
    preload(5'd5, 64'hFFFF_FFFF_8000_0012);
    preload(5'd0, 64'h33);

    // Doubleword load
    req(0, 3'b011, 8'h10, 0, edges);
    chk("ld_lat", edges, 2);
    chk("ld_rdata", rdata, 64'h5E);
    chk("ld_nowe", we_cnt, 0);
    chk("ld_mis", misaligned, 0);

    // Sub-doubleword loads from word 5 (bytes 12 00 00 80 FF FF FF FF)
    req(0, 3'b000, 8'h28, 0, edges); chk("lb", rdata, 64'h12);
    req(0, 3'b010, 8'h28, 0, edges); chk("lw", rdata, 64'hFFFF_FFFF_8000_0012);
    req(0, 3'b110, 8'h28, 0, edges); chk("lwu", rdata, 64'h0000_0000_8000_0012);
    req(0, 3'b001, 8'h2A, 0, edges); chk("lh_2a", rdata, 64'hFFFF_FFFF_FFFF_8000);
    req(0, 3'b100, 8'h2B, 0, edges); chk("lbu_2b", rdata, 64'h80);
    req(0, 3'b000, 8'h2B, 0, edges); chk("lb_2b", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    req(0, 3'b101, 8'h2E, 0, edges); chk("lhu_2e", rdata, 64'hFFFF);

    // Byte store via read-modify-write
    req(1, 3'b000, 8'h01, 64'hAB, edges);
    chk("sb_lat", edges, 3);
    chk("sb_we_cnt", we_cnt, 1);
    chk("sb_we_addr", we_addr, 0);
    chk("sb_we_din", we_din, 64'hAB33);
    chk("sb_rdata_kept", rdata, 64'hFFFF);
    chk("sb_mem0", mem[0], 64'hAB33);
    req(0, 3'b011, 8'h00, 0, edges); chk("ld0_after_sb", rdata, 64'hAB33);

    // Aligned word store, then misaligned half load
    req(1, 3'b010, 8'h04, 64'h1122_3344, edges);
    chk("sw_lat", edges, 3);
    chk("sw_mis", misaligned, 0);
    chk("sw_ill", illegal, 0);
    req(0, 3'b001, 8'h03, 0, edges);
    chk("lh_mis_lat", edges, 1);
    chk("lh_mis", misaligned, 1);
    chk("lh_mis_ill", illegal, 0);
    chk("lh_mis_rdata", rdata, 64'hAB33);
    chk("lh_mis_nowe", we_cnt, 0);
    req(0, 3'b011, 8'h00, 0, edges); chk("ld0_after_sw", rdata, 64'h1122_3344_0000_AB33);

    // Illegal encodings
    req(0, 3'b111, 8'h00, 0, edges);
    chk("ill_ld_lat", edges, 1);
    chk("ill_ld", illegal, 1);
    chk("ill_ld_mis", misaligned, 0);
    chk("ill_ld_rdata", rdata, 64'h1122_3344_0000_AB33);
    req(1, 3'b100, 8'h00, 64'hDEAD, edges);
    chk("ill_st", illegal, 1);
    chk("ill_st_nowe", we_cnt, 0);
    chk("ill_st_mem0", mem[0], 64'h1122_3344_0000_AB33);

    // Full doubleword store skips the read
    req(1, 3'b011, 8'h18, 64'h0123_4567_89AB_CDEF, edges);
    chk("sd_lat", edges, 2);
    chk("sd_we_cnt", we_cnt, 1);
    chk("sd_we_addr", we_addr, 3);
    chk("sd_mem3", mem[3], 64'h0123_4567_89AB_CDEF);
    chk("sd_rdata_kept", rdata, 64'h1122_3344_0000_AB33);

    // start held high: accepted only in IDLE, so a 2-edge load completes every 3 edges
    while (busy) begin @(posedge clk); #1; end
    we_cnt = 0; dones = 0;
    start = 1'b1; op_store = 1'b0; funct3 = 3'b011; addr = 8'h10;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    start = 1'b0;
    chk("held_dones", dones, 3);
    chk("held_nowe", we_cnt, 0);
    chk("held_rdata", rdata, 64'h5E);

    // Reset during the write cycle of a half store
    while (busy) begin @(posedge clk); #1; end
    start = 1'b1; op_store = 1'b1; funct3 = 3'b001; addr = 8'h12; wdata = 64'hBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("sh_we_pre", mem_we, 1);
    chk("sh_addr_pre", mem_addr, 2);
    chk("sh_din_pre", mem_din, 64'hBEEF_005E);
    reset = 1'b1;
    #1;
    chk("sh_rst_we", mem_we, 0);
    chk("sh_rst_busy", busy, 0);
    chk("sh_rst_done", done, 0);
    chk("sh_rst_rdata", rdata, 0);
    chk("sh_rst_maddr", mem_addr, 0);
    chk("sh_rst_mdin", mem_din, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("sh_rst_mem2", mem[2], 64'h5E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
